// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit.
//   pc_state_e : control state (reset hold, running, halted)
//   pc_sel_e   : next-PC source, listed highest priority first
//   Def*Vector : default reset and trap entry addresses
package pc_pkg;

    typedef enum logic [1:0] {
        StResetHold,
        StRun,
        StHalt
    } pc_state_e;

    typedef enum logic [2:0] {
        SelTrap,
        SelMisalign,
        SelRedirect,
        SelIncr,
        SelHold
    } pc_sel_e;

    localparam logic [31:0] DefResetVector = 32'h0000_0000;
    localparam logic [31:0] DefTrapVector  = 32'h0000_0004;

endpackage

// File: rtl/pc_incr.sv
// Constant-step PC adder.
//   a   : input address
//   sum : a + STEP, modulo 2^XLEN
module pc_incr #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 1
) (
    input  logic [XLEN-1:0] a,
    output logic [XLEN-1:0] sum
);

    assign sum = a + XLEN'(STEP);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: holds the PC, advances it on each accepted
// fetch and applies trap / redirect with fixed priority.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : blocks the fetch handshake
//   halt, resume      : enter / leave the halted state
//   redirect_valid/_target, trap_valid : control-flow change requests
//   fetch_ready       : instruction memory accepts fetch_pc
//   fetch_valid, fetch_pc : fetch request towards instruction memory
//   pc_plus_step      : fetch_pc + STEP (link value)
//   misaligned_err    : pulse the cycle after a misaligned redirect
//   fetch_count       : number of accepted fetches, wrapping
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     STEP         = 1,
    parameter int unsigned     ALIGN_BITS   = 0,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DefResetVector),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DefTrapVector),
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  fetch_pc,
    output logic [XLEN-1:0]  pc_plus_step,
    output logic             misaligned_err,
    output logic [CNT_W-1:0] fetch_count
);

    // Low bits of a redirect target that must be zero; all-zero mask when ALIGN_BITS is 0.
    localparam logic [XLEN-1:0] AlignMask = ~({XLEN{1'b1}} << ALIGN_BITS);

    pc_state_e        state_q, state_d;
    pc_sel_e          sel;
    logic [XLEN-1:0]  pc_q, pc_d, pc_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             fire, misaligned, jump;

    // Single adder shared by the link output and the increment path.
    pc_incr #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_pc_incr (
        .a   (pc_q),
        .sum (pc_inc)
    );

    assign fetch_valid    = (state_q == StRun);
    assign fetch_pc       = pc_q;
    assign pc_plus_step   = pc_inc;
    assign misaligned_err = err_q;
    assign fetch_count    = cnt_q;

    assign fire       = fetch_valid & fetch_ready & ~stall;
    assign misaligned = |(redirect_target & AlignMask);
    assign jump       = trap_valid | redirect_valid;

    always_comb begin
        sel = SelHold;
        if (trap_valid)                        sel = SelTrap;
        else if (redirect_valid && misaligned) sel = SelMisalign;
        else if (redirect_valid)               sel = SelRedirect;
        else if (fire)                         sel = SelIncr;
    end

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        unique case (sel)
            SelTrap:     pc_d = TRAP_VECTOR;
            SelMisalign: begin
                pc_d  = TRAP_VECTOR;
                err_d = 1'b1;
            end
            SelRedirect: pc_d = redirect_target;
            SelIncr: begin
                pc_d  = pc_inc;
                cnt_d = cnt_q + CNT_W'(1);
            end
            SelHold:     pc_d = pc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StResetHold: state_d = StRun;
            StRun: begin
                // A same-cycle redirect or trap keeps the unit running.
                if (!jump && halt) state_d = StHalt;
            end
            StHalt: begin
                if (jump)         state_d = StRun;
                else if (halt)    state_d = StHalt;
                else if (resume)  state_d = StRun;
            end
            default:             state_d = StResetHold;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StResetHold;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (no alignment check, 2-bit alignment)
// driven by the same stimulus, compared every cycle against a behavioural model,
// plus literal expectations from the directed scenarios.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0;
    localparam logic [31:0] TV = 32'h4;
    localparam int CNT_MOD = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, halt = 1'b0, resume = 1'b0;
    logic        redirect_valid = 1'b0, trap_valid = 1'b0, fetch_ready = 1'b0;
    logic [31:0] redirect_target = 32'h0;

    logic        fv0, fv1, err0, err1;
    logic [31:0] pc0, pc1, ps0, ps1;
    logic [7:0]  cnt0, cnt1;

    int checks = 0;
    int failures = 0;

    // Model state per instance.
    logic [31:0] m_pc[2];
    int          m_cnt[2];
    bit          m_err[2];
    int          m_mode[2];   // 0 reset hold, 1 run, 2 halt
    int          align[2] = '{0, 2};

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .XLEN(32), .STEP(1), .ALIGN_BITS(0), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(8)
    ) u0 (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .fetch_ready(fetch_ready), .fetch_valid(fv0),
        .fetch_pc(pc0), .pc_plus_step(ps0), .misaligned_err(err0), .fetch_count(cnt0)
    );

    pc_fetch_unit #(
        .XLEN(32), .STEP(1), .ALIGN_BITS(2), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(8)
    ) u1 (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .fetch_ready(fetch_ready), .fetch_valid(fv1),
        .fetch_pc(pc1), .pc_plus_step(ps1), .misaligned_err(err1), .fetch_count(cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // Apply the rules to the inputs currently driven; results become visible after the edge.
    task automatic model_edge();
        logic [31:0] n_pc[2];
        int          n_cnt[2], n_mode[2];
        bit          n_err[2];
        for (int i = 0; i < 2; i++) begin
            bit valid, fire, mis, jump;
            valid     = (m_mode[i] == 1);
            fire      = valid && fetch_ready && !stall;
            mis       = redirect_valid && ((redirect_target % (32'd1 << align[i])) != 0);
            jump      = trap_valid || redirect_valid;
            n_pc[i]   = m_pc[i];
            n_cnt[i]  = m_cnt[i];
            n_err[i]  = 0;
            if (trap_valid) n_pc[i] = TV;
            else if (mis) begin
                n_pc[i]  = TV;
                n_err[i] = 1;
            end else if (redirect_valid) n_pc[i] = redirect_target;
            else if (fire) begin
                n_pc[i]  = m_pc[i] + 32'd1;
                n_cnt[i] = (m_cnt[i] + 1) % CNT_MOD;
            end
            if (m_mode[i] == 0 || jump) n_mode[i] = 1;
            else if (halt)              n_mode[i] = 2;
            else if (m_mode[i] == 2)    n_mode[i] = resume ? 1 : 2;
            else                        n_mode[i] = 1;
            if (rst) begin
                n_pc[i] = RV; n_cnt[i] = 0; n_err[i] = 0; n_mode[i] = 0;
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = n_pc[i]; m_cnt[i] = n_cnt[i]; m_err[i] = n_err[i]; m_mode[i] = n_mode[i];
        end
    endtask

    task automatic compare_all();
        chk("u0.fetch_valid",  {31'd0, fv0}, {31'd0, m_mode[0] == 1});
        chk("u0.fetch_pc",     pc0, m_pc[0]);
        chk("u0.pc_plus_step", ps0, m_pc[0] + 32'd1);
        chk("u0.misaligned",   {31'd0, err0}, {31'd0, m_err[0]});
        chk("u0.fetch_count",  {24'd0, cnt0}, 32'(m_cnt[0]));
        chk("u1.fetch_valid",  {31'd0, fv1}, {31'd0, m_mode[1] == 1});
        chk("u1.fetch_pc",     pc1, m_pc[1]);
        chk("u1.pc_plus_step", ps1, m_pc[1] + 32'd1);
        chk("u1.misaligned",   {31'd0, err1}, {31'd0, m_err[1]});
        chk("u1.fetch_count",  {24'd0, cnt1}, 32'(m_cnt[1]));
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; halt = 0; resume = 0;
        redirect_valid = 0; trap_valid = 0; fetch_ready = 0; redirect_target = 0;
    endtask

    initial begin
        // Reset and run.
        rst = 1;
        repeat (3) tick();
        chk("rst.valid", {31'd0, fv0}, 32'd0);
        chk("rst.pc", pc0, 32'h0);
        chk("rst.count", {24'd0, cnt0}, 32'd0);
        rst = 0; fetch_ready = 1;
        tick();
        chk("run.first_valid", {31'd0, fv0}, 32'd1);
        chk("run.first_pc", pc0, 32'h0);
        repeat (4) tick();
        chk("run.pc_after4", pc0, 32'h4);
        chk("run.count_after4", {24'd0, cnt0}, 32'd4);

        // Stall and backpressure at PC=5.
        tick();
        fetch_ready = 0; tick();
        fetch_ready = 1; stall = 1; tick();
        tick();
        chk("stall.pc", pc0, 32'h5);
        chk("stall.count", {24'd0, cnt0}, 32'd5);
        stall = 0; tick();
        chk("stall.release_pc", pc0, 32'h6);

        // Trap beats redirect beats fire.
        trap_valid = 1; redirect_valid = 1; redirect_target = 32'h40; tick();
        chk("prio.pc", pc0, TV);
        chk("prio.count", {24'd0, cnt0}, 32'd6);

        // Misalignment on the aligned instance.
        trap_valid = 0; redirect_target = 32'h102; tick();
        chk("mis.u1_pc", pc1, TV);
        chk("mis.u1_err", {31'd0, err1}, 32'd1);
        chk("mis.u0_pc", pc0, 32'h102);
        redirect_valid = 0; fetch_ready = 0; tick();
        chk("mis.u1_err_clear", {31'd0, err1}, 32'd0);
        redirect_valid = 1; redirect_target = 32'h100; tick();
        chk("mis.u1_aligned_pc", pc1, 32'h100);
        chk("mis.u1_aligned_err", {31'd0, err1}, 32'd0);

        // Halt with same-cycle fire, then resume.
        redirect_target = 32'h7; tick();
        redirect_valid = 0; halt = 1; fetch_ready = 1; tick();
        chk("halt.pc", pc0, 32'h8);
        chk("halt.valid", {31'd0, fv0}, 32'd0);
        halt = 0; tick();
        chk("halt.hold_pc", pc0, 32'h8);
        resume = 1; tick();
        chk("resume.valid", {31'd0, fv0}, 32'd1);
        chk("resume.pc", pc0, 32'h8);
        resume = 0;

        // PC wrap.
        fetch_ready = 0; redirect_valid = 1; redirect_target = 32'hFFFF_FFFF; tick();
        chk("wrap.pc", pc0, 32'hFFFF_FFFF);
        chk("wrap.plus_step", ps0, 32'h0);
        redirect_valid = 0; fetch_ready = 1; tick();
        chk("wrap.pc_after_fire", pc0, 32'h0);

        // Reset while halted.
        halt = 1; tick();
        halt = 0; rst = 1; tick();
        chk("midrst_halt.pc", pc0, RV);
        chk("midrst_halt.count", {24'd0, cnt0}, 32'd0);
        chk("midrst_halt.valid", {31'd0, fv0}, 32'd0);
        rst = 0; tick(); tick();

        // Reset during a stalled request.
        redirect_valid = 1; redirect_target = 32'h20; tick();
        redirect_valid = 0; stall = 1; tick();
        rst = 1; tick();
        chk("midrst_stall.pc", pc0, RV);
        chk("midrst_stall.count", {24'd0, cnt0}, 32'd0);
        chk("midrst_stall.valid", {31'd0, fv0}, 32'd0);
        chk("midrst_stall.err", {31'd0, err1}, 32'd0);
        idle_inputs();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst            = ($urandom_range(0, 1499) == 0);
            trap_valid     = ($urandom_range(0, 24) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            halt           = ($urandom_range(0, 19) == 0);
            resume         = ($urandom_range(0, 3) == 0);
            stall          = ($urandom_range(0, 4) == 0);
            fetch_ready    = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       redirect_target = $urandom;
                1:       redirect_target = $urandom & 32'hFFFF_FFFC;
                2:       redirect_target = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                default: redirect_target = 32'($urandom_range(0, 15));
            endcase
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter unit for the fetch stage: holds the architectural PC, advances it by a configurable step on each accepted fetch, and applies branch/jump redirects and trap entry with fixed priority. Presents the current fetch address to instruction memory through a valid/ready handshake. Supports halt/resume and keeps a count of accepted fetches. Sits between the control/branch logic and the instruction memory, and replaces the bare combinational PC incrementer.

## Interface
- `XLEN`, 32: PC width in bits.
- `STEP`, 1: increment per accepted fetch. The default of 1 means word-addressed instruction memory.
- `ALIGN_BITS`, 0: number of low target bits that must be zero. 0 disables the alignment check.
- `RESET_VECTOR`, 0: PC loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0004: PC loaded on trap or on misaligned redirect.
- `CNT_W`, 32: width of the fetch counter.

- `clk` input 1: the single clock. Everything is sampled on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: blocks the fetch handshake. The PC holds.
- `halt` input 1: requests entry to HALT.
- `resume` input 1: leaves HALT.
- `redirect_valid` input 1: branch/jump taken.
- `redirect_target` input XLEN: branch/jump destination.
- `trap_valid` input 1: trap entry request.
- `fetch_ready` input 1: instruction memory accepts the address.
- `fetch_valid` output 1: `fetch_pc` is a valid request.
- `fetch_pc` output XLEN: current PC.
- `pc_plus_step` output XLEN: combinational `fetch_pc + STEP`, truncated to XLEN. Used for the link register.
- `misaligned_err` output 1: one-cycle pulse when a redirect target fails the alignment check.
- `fetch_count` output CNT_W: number of accepted fetches.

## Operation
- States: RESET_HOLD, RUN, HALT.
- Reset (`rst`=1) drives the block to RESET_HOLD with these values:
  - `fetch_pc` = RESET_VECTOR
  - `fetch_valid` = 0
  - `misaligned_err` = 0
  - `fetch_count` = 0
- RESET_HOLD always moves to RUN on the next cycle. `fetch_valid` stays 0 for that one cycle.
- RUN: `fetch_valid` = 1.
  - Fire is defined as `fetch_valid & fetch_ready & ~stall`.
  - On fire, `fetch_pc` advances by STEP and `fetch_count` increments.
- Handshake: when there is no fire, `fetch_pc` holds stable. The only exception is a redirect or trap.
- Redirect priority, highest first. Each applies in any non-reset state and overrides `stall` and an outstanding handshake:
  1. `trap_valid`: PC ← TRAP_VECTOR.
  2. `redirect_valid` with a misaligned target: PC ← TRAP_VECTOR and `misaligned_err` pulses.
  3. `redirect_valid` with an aligned target: PC ← `redirect_target`.
  4. Fire: PC ← PC + STEP.
  5. Otherwise: PC holds.
- A redirect cancels the same-cycle fire. The old PC is not counted and not incremented.
- A redirect or trap in HALT loads the new PC and moves to RUN.
- A redirect or trap in RESET_HOLD loads the new PC. The block still goes to RUN.
- `halt` in RUN with no redirect or trap: go to HALT next cycle.
  - A fire in the same cycle still completes, so the PC advances before halting.
  - In HALT: `fetch_valid` = 0, PC holds, the counter holds.
- `resume` in HALT: go to RUN. If `halt` and `resume` are both high, HALT wins.
- Arithmetic:
  - PC addition is modulo 2^XLEN, so all-ones + 1 wraps to 0.
  - `fetch_count` wraps modulo 2^CNT_W.
- `rst` asserted mid-operation, in any state and with any handshake outstanding, returns the block to reset values on the next edge. There is no partial update.

## Timing
- Redirect and trap latency is 1 cycle: the target appears on `fetch_pc` in the cycle after the request.
- Increment latency is 1 cycle after fire. Back-to-back fires issue one address per cycle.
- `misaligned_err` is registered. It is high for exactly the cycle after the offending request.
- `pc_plus_step` has zero latency from `fetch_pc`.
- The first valid fetch is 2 edges after `rst` deasserts: first RESET_HOLD, then RUN with `fetch_valid` = 1.

## Structure
- Shared package `pc_pkg` holds:
  - the state enum (RESET_HOLD, RUN, HALT);
  - default RESET_VECTOR and TRAP_VECTOR constants;
  - the next-PC source select encoding (TRAP, MISALIGN, REDIRECT, INCR, HOLD).
- One sub-module, `pc_incr`: parametrised adder computing `a + STEP` at XLEN width. It is instantiated once for both `pc_plus_step` and the next-PC increment path.
- The top level contains the FSM, the priority mux, the alignment check and the counter.

## Test plan
- Reset and run: hold `rst` 3 cycles, then `fetch_ready`=1. Required response:
  - `fetch_valid`=0 for one cycle;
  - `fetch_pc` then steps 0, 1, 2, 3;
  - `fetch_count` reaches 4 after 4 fires.
- Stall and backpressure: `fetch_ready`=0 or `stall`=1 for 3 cycles at PC=5. `fetch_pc` holds at 5 and the count does not change. On release, the PC advances to 6.
- Priority: in the same cycle, `trap_valid`=1, `redirect_valid`=1 with target 0x40, and fire. Next cycle: `fetch_pc`=TRAP_VECTOR, the count is unchanged, and the old PC is not incremented.
- Misalignment: with ALIGN_BITS=2, redirect to 0x102. Next cycle: `fetch_pc`=TRAP_VECTOR and `misaligned_err`=1 for exactly 1 cycle. A redirect to 0x100 loads 0x100 with no error.
- Halt/resume and wrap:
  - `halt` at PC=7 with fire gives HALT at PC=8, `fetch_valid`=0. `resume` gives RUN at 8.
  - Redirect to 0xFFFF_FFFF, then fire, gives `fetch_pc`=0.
- Mid-operation reset: assert `rst` in HALT and again during a stalled request. Both times all outputs return to reset values on the next edge.
